// File: rtl/core_wb_arbiter.sv
// Writeback arbiter: merges fast (ALU/load) and slow (mul/div) results into one registered
// regfile write per cycle and tracks pending slow destinations. WB_FORWARD_EN adds operand forwarding.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module core_wb_arbiter #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int SLOW_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fast_valid_i,
    input  logic [4:0]            fast_rd_i,
    input  logic [DATA_WIDTH-1:0] fast_data_i,
    input  logic                  slow_valid_i,
    output logic                  slow_ready_o,
    input  logic [4:0]            slow_rd_i,
    input  logic [DATA_WIDTH-1:0] slow_data_i,
    input  logic                  issue_slow_i,
    input  logic [4:0]            issue_rd_i,
    input  logic [4:0]            rs1_addr_i,
    input  logic [4:0]            rs2_addr_i,
    output logic                  rs1_busy_o,
    output logic                  rs2_busy_o,
`ifdef WB_FORWARD_EN
    input  logic [DATA_WIDTH-1:0] rs1_data_i,
    input  logic [DATA_WIDTH-1:0] rs2_data_i,
    output logic [DATA_WIDTH-1:0] rs1_data_o,
    output logic [DATA_WIDTH-1:0] rs2_data_o,
`endif
    output logic                  regfile_we_o,
    output logic [4:0]            regfile_waddr_o,
    output logic [DATA_WIDTH-1:0] regfile_data_o
);

    localparam int PW = $clog2(SLOW_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [4:0]            rd;
        logic [DATA_WIDTH-1:0] data;
    } wb_entry_t;

    wb_entry_t             fifo_q [SLOW_DEPTH];
    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [31:0]           pend_q, pend_d;
    logic                  we_q, we_d;
    logic [4:0]            waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic      empty, full, push, pop, sel_vld;
    wb_entry_t head, sel;

    assign empty        = (cnt_q == '0);
    assign full         = (cnt_q == CW'(SLOW_DEPTH));
    assign slow_ready_o = !full;
    assign push         = slow_valid_i && !full;
    // Fast results are always accepted, so the queue only drains on fast-idle cycles.
    assign pop          = !fast_valid_i && !empty;
    assign head         = fifo_q[rptr_q];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push) wptr_d = wptr_q + PW'(1);
        if (pop)  rptr_d = rptr_q + PW'(1);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        sel_vld = 1'b0;
        sel     = '0;
        if (fast_valid_i) begin
            sel_vld = 1'b1;
            sel.rd   = fast_rd_i;
            sel.data = fast_data_i;
        end else if (!empty) begin
            sel_vld = 1'b1;
            sel     = head;
        end
        we_d    = sel_vld && (sel.rd != 5'd0);
        waddr_d = sel_vld ? sel.rd   : waddr_q;
        data_d  = sel_vld ? sel.data : data_q;
    end

    // Clear for the popped rd first so a same-cycle issue to that rd keeps it pending.
    always_comb begin
        pend_d = pend_q;
        if (pop) pend_d[head.rd] = 1'b0;
        if (issue_slow_i && (issue_rd_i != 5'd0)) pend_d[issue_rd_i] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            pend_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            data_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            data_q  <= data_d;
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wptr_q].rd   <= slow_rd_i;
            fifo_q[wptr_q].data <= slow_data_i;
        end
    end

    assign regfile_we_o    = we_q;
    assign regfile_waddr_o = waddr_q;
    assign regfile_data_o  = data_q;

    logic rs1_hit, rs2_hit;
    assign rs1_hit = we_q && (waddr_q == rs1_addr_i) && (rs1_addr_i != 5'd0);
    assign rs2_hit = we_q && (waddr_q == rs2_addr_i) && (rs2_addr_i != 5'd0);

`ifdef WB_FORWARD_EN
    assign rs1_data_o = rs1_hit ? data_q : rs1_data_i;
    assign rs2_data_o = rs2_hit ? data_q : rs2_data_i;
    assign rs1_busy_o = (rs1_addr_i != 5'd0) && pend_q[rs1_addr_i];
    assign rs2_busy_o = (rs2_addr_i != 5'd0) && pend_q[rs2_addr_i];
`else
    // Without forwarding, the value being written this cycle is not yet readable.
    assign rs1_busy_o = (rs1_addr_i != 5'd0) && (pend_q[rs1_addr_i] || rs1_hit);
    assign rs2_busy_o = (rs2_addr_i != 5'd0) && (pend_q[rs2_addr_i] || rs2_hit);
`endif

endmodule

// File: tb/tb_core_wb_arbiter.sv
// Directed bench for core_wb_arbiter with a queue-based reference model and write scoreboard.
module tb_core_wb_arbiter;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fast_valid_i, slow_valid_i, issue_slow_i;
    logic [4:0]    fast_rd_i, slow_rd_i, issue_rd_i, rs1_addr_i, rs2_addr_i;
    logic [DW-1:0] fast_data_i, slow_data_i;
    logic          slow_ready_o, rs1_busy_o, rs2_busy_o, regfile_we_o;
    logic [4:0]    regfile_waddr_o;
    logic [DW-1:0] regfile_data_o;
`ifdef WB_FORWARD_EN
    logic [DW-1:0] rs1_data_i, rs2_data_i, rs1_data_o, rs2_data_o;
`endif

    always #5 clk = ~clk;

    core_wb_arbiter #(.DATA_WIDTH(DW), .SLOW_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .fast_valid_i(fast_valid_i), .fast_rd_i(fast_rd_i), .fast_data_i(fast_data_i),
        .slow_valid_i(slow_valid_i), .slow_ready_o(slow_ready_o),
        .slow_rd_i(slow_rd_i), .slow_data_i(slow_data_i),
        .issue_slow_i(issue_slow_i), .issue_rd_i(issue_rd_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o),
`ifdef WB_FORWARD_EN
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
`endif
        .regfile_we_o(regfile_we_o), .regfile_waddr_o(regfile_waddr_o),
        .regfile_data_o(regfile_data_o)
    );

    typedef struct {
        logic [4:0]    rd;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          mq[$];   // model of the slow queue
    ent_t          sb[$];   // expected regfile writes
    logic [31:0]   mpend;
    logic          mwe;
    logic [4:0]    mwaddr;
    logic [DW-1:0] mdata;
    logic          acc;
    int            nvec = 0;
    int            nerr = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic mbusy(input logic [4:0] a);
        logic b;
        b = (a != 5'd0) && mpend[a];
`ifndef WB_FORWARD_EN
        b = b || (mwe && mwaddr == a && a != 5'd0);
`endif
        return b;
    endfunction

    task automatic model_reset();
        mq.delete();
        sb.delete();
        mpend  = '0;
        mwe    = 1'b0;
        mwaddr = '0;
        mdata  = '0;
    endtask

    // One clock: check combinational outputs, advance the model, then check the registered write.
    task automatic step();
        logic exp_ready, sel, exp_we;
        ent_t s, e;
        #1;
        exp_ready = (mq.size() < DEPTH);
        chk("slow_ready", slow_ready_o, exp_ready);
        chk("rs1_busy", rs1_busy_o, mbusy(rs1_addr_i));
        chk("rs2_busy", rs2_busy_o, mbusy(rs2_addr_i));
`ifdef WB_FORWARD_EN
        chk("rs1_fwd", rs1_data_o, (mwe && mwaddr == rs1_addr_i && rs1_addr_i != 0) ? mdata : rs1_data_i);
        chk("rs2_fwd", rs2_data_o, (mwe && mwaddr == rs2_addr_i && rs2_addr_i != 0) ? mdata : rs2_data_i);
`endif
        sel = 1'b0;
        if (fast_valid_i) begin
            sel = 1'b1; s.rd = fast_rd_i; s.data = fast_data_i;
        end else if (mq.size() > 0) begin
            sel = 1'b1; s = mq.pop_front();
            mpend[s.rd] = 1'b0;
        end
        exp_we = sel && (s.rd != 0);
        if (exp_we) sb.push_back(s);
        acc = slow_valid_i && exp_ready;
        if (acc) begin
            e.rd = slow_rd_i; e.data = slow_data_i;
            mq.push_back(e);
        end
        if (issue_slow_i && issue_rd_i != 0) mpend[issue_rd_i] = 1'b1;
        @(posedge clk);
        #1;
        chk("regfile_we", regfile_we_o, exp_we);
        if (exp_we && sb.size() > 0) begin
            e = sb.pop_front();
            chk("regfile_waddr", regfile_waddr_o, e.rd);
            chk("regfile_data", regfile_data_o, e.data);
        end
        mwe = exp_we;
        if (sel) begin mwaddr = s.rd; mdata = s.data; end
    endtask

    task automatic idle();
        fast_valid_i = 0; slow_valid_i = 0; issue_slow_i = 0;
    endtask

    // Offer a slow result and hold it until accepted, with a bounded wait.
    task automatic slow_send(input logic [4:0] rd, input logic [DW-1:0] d);
        int n = 0;
        slow_valid_i = 1; slow_rd_i = rd; slow_data_i = d;
        acc = 0;
        while (!acc && n < 10) begin step(); n++; end
        if (!acc) chk("slow_accept_timeout", 1'b0, 1'b1);
        slow_valid_i = 0;
    endtask

    initial begin
        rst_n = 0;
        fast_valid_i = 0; fast_rd_i = 0; fast_data_i = 0;
        slow_valid_i = 0; slow_rd_i = 0; slow_data_i = 0;
        issue_slow_i = 0; issue_rd_i = 0; rs1_addr_i = 0; rs2_addr_i = 0;
`ifdef WB_FORWARD_EN
        rs1_data_i = 32'h1111_0001; rs2_data_i = 32'h2222_0002;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        #1;
        chk("rst_we", regfile_we_o, 1'b0);
        chk("rst_waddr", regfile_waddr_o, 5'd0);
        chk("rst_data", regfile_data_o, 32'h0);
        chk("rst_ready", slow_ready_o, 1'b1);
        chk("rst_busy1", rs1_busy_o, 1'b0);
        chk("rst_busy2", rs2_busy_o, 1'b0);

        // Fast writes, including rd=0 which must not write.
        rs1_addr_i = 5; rs2_addr_i = 0;
        fast_valid_i = 1; fast_rd_i = 5; fast_data_i = 32'h1234; step();
        fast_rd_i = 0; fast_data_i = 32'hDEAD; step();
        idle(); step();
        fast_valid_i = 1; fast_rd_i = 5; fast_data_i = 32'h5555; step();
        idle(); step();

        // Fast priority while two slow results queue up, then drain in order.
        fast_valid_i = 1; fast_rd_i = 1; fast_data_i = 32'h100;
        slow_valid_i = 1; slow_rd_i = 3; slow_data_i = 32'hA; step();
        fast_data_i = 32'h101; slow_rd_i = 4; slow_data_i = 32'hB; step();
        slow_valid_i = 0; fast_data_i = 32'h102; step();
        #1 chk("full_ready_low", slow_ready_o, 1'b0);
        // Full with a waiting producer: pop happens, push waits for the next cycle.
        fast_valid_i = 0;
        slow_send(5'd6, 32'hC);
        idle(); repeat (3) step();
        chk("sb_drained", sb.size(), 0);

        // Scoreboard: issue rd7, operand reads busy until the slow result writes back.
        rs1_addr_i = 7; rs2_addr_i = 8;
        issue_slow_i = 1; issue_rd_i = 7; step();
        issue_slow_i = 0; step();
        chk("busy_rd7", rs1_busy_o, 1'b1);
        slow_send(5'd7, 32'h77); step();
        step(); step();

        // Set wins over clear: issue rd9 on the cycle its earlier slow result pops.
        rs1_addr_i = 9; rs2_addr_i = 9;
        issue_slow_i = 1; issue_rd_i = 9; step();
        issue_slow_i = 0; slow_send(5'd9, 32'h99);
        issue_slow_i = 1; issue_rd_i = 9; step();
        issue_slow_i = 0; step(); step();
        chk("pend9_kept", rs2_busy_o, 1'b1);

        // Mid-operation reset with two queued entries and pending bits.
        rs1_addr_i = 10; rs2_addr_i = 11;
        fast_valid_i = 1; fast_rd_i = 2; fast_data_i = 32'h200;
        issue_slow_i = 1; issue_rd_i = 10; slow_valid_i = 1; slow_rd_i = 10; slow_data_i = 32'hA0; step();
        issue_rd_i = 11; slow_rd_i = 11; slow_data_i = 32'hB0; step();
        idle();
        rst_n = 0; #2;
        chk("mrst_we", regfile_we_o, 1'b0);
        chk("mrst_data", regfile_data_o, 32'h0);
        rst_n = 1;
        model_reset();
        repeat (3) step();
        chk("mrst_busy1", rs1_busy_o, 1'b0);
        chk("mrst_busy2", rs2_busy_o, 1'b0);
        chk("mrst_ready", slow_ready_o, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
